// File: rtl/seg_frame_tx.sv
// seg_frame_tx: serial frame transmitter for the three-wire display link (shift clock, data, latch).
// Define SEGTX_REFRESH_EN to retransmit the last frame after REFRESH_CYCLES idle cycles.
module seg_frame_tx #(
    parameter int FRAME_BITS     = 96,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] frame_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  ser_clk,
    output logic                  ser_data,
    output logic                  ser_latch,
    output logic                  frame_done
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(FRAME_BITS) + 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH_SETUP, LATCH_HI, GAP} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic                  ready_q, ready_d, sclk_q, sclk_d, sdata_q, sdata_d;
    logic                  latch_q, latch_d, done_q, done_d;
    logic                  start, load, last_div;
    logic [FRAME_BITS-1:0] load_data;

    assign start    = frame_valid && ready_q;
    assign last_div = div_q == DW'(CLK_DIV - 1);

`ifdef SEGTX_REFRESH_EN
    localparam int IW = $clog2(REFRESH_CYCLES + 1);
    logic [FRAME_BITS-1:0] last_q, last_d;
    logic                  have_q, have_d;
    logic [IW-1:0]         idle_q, idle_d;
    // A fresh handshake always takes priority over a refresh expiring in the same cycle.
    assign load      = start || (ready_q && have_q && idle_q == IW'(REFRESH_CYCLES - 1));
    assign load_data = start ? frame_data : last_q;
    always_comb begin
        last_d = start ? frame_data : last_q;
        have_d = have_q || start;
        idle_d = (ready_q && !load) ? idle_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
            have_q <= 1'b0;
            idle_q <= '0;
        end else begin
            last_q <= last_d;
            have_q <= have_d;
            idle_q <= idle_d;
        end
    end
`else
    assign load      = start;
    assign load_data = frame_data;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (state_q == IDLE) begin
            bit_d = '0;
            if (load) begin
                state_d = SHIFT_LO;
                sh_d    = load_data;
            end
        end else begin
            div_d = last_div ? '0 : div_q + 1'b1;
            if (last_div) begin
                state_d = state_q == SHIFT_LO    ? SHIFT_HI :
                          state_q == SHIFT_HI    ? (bit_q == BW'(FRAME_BITS - 1) ? LATCH_SETUP : SHIFT_LO) :
                          state_q == LATCH_SETUP ? LATCH_HI :
                          state_q == LATCH_HI    ? GAP : IDLE;
                if (state_q == SHIFT_HI) begin
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + 1'b1;
                end
            end
        end
        // Outputs are registered from the next state so they change on the same edge as the state.
        ready_d = state_d == IDLE;
        sclk_d  = state_d == SHIFT_HI;
        latch_d = state_d == LATCH_HI;
        done_d  = state_d == GAP && state_q != GAP;
        sdata_d = state_d == SHIFT_LO ? sh_d[FRAME_BITS-1] : (state_d == SHIFT_HI && sdata_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            latch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            latch_q <= latch_d;
            done_q  <= done_d;
        end
    end

    assign frame_ready = ready_q;
    assign ser_clk     = sclk_q;
    assign ser_data    = sdata_q;
    assign ser_latch   = latch_q;
    assign frame_done  = done_q;
endmodule

// File: tb/tb_seg_frame_tx.sv
// tb_seg_frame_tx: directed bench for seg_frame_tx at default parameters.
module tb_seg_frame_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] frame_data = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready, ser_clk, ser_data, ser_latch, frame_done;

    seg_frame_tx dut (
        .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .ser_clk(ser_clk), .ser_data(ser_data),
        .ser_latch(ser_latch), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model and event recorder, sampled mid-cycle.
    logic [95:0] rx, cap;
    int rises, first_rise, lat_n, lat_w, done_n, done_rel, ready_rel, low_n, ov;
    logic pclk = 1'b0, plat = 1'b0, prdy = 1'b1;

    task automatic clr();
        rx = '0; cap = '0; rises = 0; first_rise = -1; lat_n = 0; lat_w = 0;
        done_n = 0; done_rel = -1; ready_rel = -1; low_n = 0; ov = 0;
    endtask

    always @(negedge clk) begin
        if (ser_clk === 1'b1 && pclk === 1'b0) begin
            rx = {rx[94:0], ser_data};
            rises++;
            if (first_rise < 0) first_rise = cyc - t0;
        end
        if (ser_latch === 1'b1) lat_w++;
        if (ser_latch === 1'b1 && plat === 1'b0) begin
            lat_n++;
            cap = rx;
        end
        if (frame_done === 1'b1) begin
            done_n++;
            done_rel = cyc - t0;
        end
        if (frame_ready === 1'b1 && prdy === 1'b0 && ready_rel < 0) ready_rel = cyc - t0;
        if (frame_ready === 1'b0) low_n++;
        if (ser_clk === 1'b1 && ser_latch === 1'b1) ov++;
        pclk = ser_clk; plat = ser_latch; prdy = frame_ready;
    end

    task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) tick();
    endtask

    task automatic send(input logic [95:0] d);
        int k = 0;
        while (frame_ready !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        chk("ready_before_send", frame_ready, 1'b1);
        frame_data = d; frame_valid = 1'b1; t0 = cyc;
        tick();
        frame_valid = 1'b0;
    endtask

    localparam logic [95:0] F1 = 96'hA5_0000_0000_0000_0000_0000_01;
    localparam logic [95:0] F2 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    localparam logic [95:0] F3 = 96'h7F00_3C00_0F00_0E00_7700_0100;
    localparam logic [95:0] FB = 96'h0055_0033_0011_0066_0022_0044;

    initial begin
        clr();
        repeat (3) tick();
        chk("rst_ready", frame_ready, 1'b1);
        chk("rst_sclk", ser_clk, 1'b0);
        chk("rst_sdata", ser_data, 1'b0);
        chk("rst_latch", ser_latch, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single frame, with a stray valid while busy.
        clr();
        send(F1);
        chk("f1_ready_drop", frame_ready, 1'b0);
        wait_rel(100);
        frame_data = F2; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        wait_rel(790);
        chk("f1_first_rise", 96'(first_rise), 96'(5));
        chk("f1_rises", 96'(rises), 96'(96));
        chk("f1_latch_n", 96'(lat_n), 96'(1));
        chk("f1_latch_w", 96'(lat_w), 96'(4));
        chk("f1_data", cap, F1);
        chk("f1_done_rel", 96'(done_rel), 96'(777));
        chk("f1_done_n", 96'(done_n), 96'(1));
        chk("f1_ready_rel", 96'(ready_rel), 96'(781));
        chk("f1_low_n", 96'(low_n), 96'(780));
        chk("f1_overlap", 96'(ov), 96'(0));

        // Reset in the middle of a frame.
        clr();
        send(F2);
        wait_rel(300);
        rst_n = 1'b0;
        tick();
        chk("mr_ready", frame_ready, 1'b1);
        chk("mr_sclk", ser_clk, 1'b0);
        chk("mr_sdata", ser_data, 1'b0);
        chk("mr_latch", ser_latch, 1'b0);
        rst_n = 1'b1;
        wait_rel(900);
        chk("mr_no_latch", 96'(lat_n), 96'(0));
        chk("mr_no_done", 96'(done_n), 96'(0));

        // Frame after the aborted one.
        clr();
        send(F3);
        wait_rel(790);
        chk("f3_data", cap, F3);
        chk("f3_rises", 96'(rises), 96'(96));
        chk("f3_latch_n", 96'(lat_n), 96'(1));

        // Valid held high: back-to-back frames.
        clr();
        send(FB);
        frame_valid = 1'b1;
        wait_rel(781);
        chk("bb_ready_781", frame_ready, 1'b1);
        tick();
        chk("bb_ready_782", frame_ready, 1'b0);
        wait_rel(1562);
        frame_valid = 1'b0;
        chk("bb_ready_1562", frame_ready, 1'b1);
        wait_rel(1570);
        chk("bb_latch_n", 96'(lat_n), 96'(2));
        chk("bb_done_n", 96'(done_n), 96'(2));
        chk("bb_rises", 96'(rises), 96'(192));
        chk("bb_data", cap, FB);
        chk("bb_overlap", 96'(ov), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
